prince_share_arbiter: RTL
=========================

PRINCE_SHARE_ARBITER -- requirements
Module: prince_share_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles to wait for core_done before aborting.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports reqN_valid (input, 1 bit) and reqN_ready (output, 1 bit), for N=0,1: the request handshake.
REQ-005 The block SHALL have the port reqN_enc, input, 1 bit, for N=0,1: 1 = encrypt, 0 = decrypt.
REQ-006 The block SHALL have the port reqN_p, input, 256 bits, for N=0,1: four 64-bit plaintext shares, share0 in bits [63:0].
REQ-007 The block SHALL have the port reqN_guard, input, 12 bits, for N=0,1: fresh guard randomness, b in [3:0], c in [7:4], d in [11:8].
REQ-008 The block SHALL have the core-side output ports core_en (1), core_enc (1), core_p (256) and core_guard (12).
REQ-009 The block SHALL have the core-side input ports core_done (1) and core_c (256, four ciphertext shares).
REQ-010 The block SHALL have the response output ports rsp_valid (1), rsp_id (1), rsp_err (1) and rsp_c (256), and the response input port rsp_ready (1).
REQ-011 The block SHALL have the port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The FSM SHALL have three states, IDLE, RUN and RESP, and only the transitions listed in REQ-013 to REQ-016.
REQ-013 In IDLE, if either reqN_valid is high, the block SHALL assert the granted reqN_ready for exactly that cycle, latch enc, p and guard into operand registers, record rsp_id=N, clear the timeout counter, and go to RUN.
REQ-014 Arbitration SHALL be round-robin on a last-grant bit: when both requesters are valid, grant the one not granted last; when only one is valid, grant it.
REQ-015 In RUN, core_en SHALL be 1 and core_enc, core_p and core_guard SHALL be driven from the operand registers and held stable; the counter SHALL increment every cycle.
REQ-016 In RUN, when core_done=1, the block SHALL capture core_c into rsp_c with rsp_err=0 and go to RESP. Otherwise, when the counter reaches TIMEOUT, it SHALL set rsp_c=0 and rsp_err=1 and go to RESP. core_done takes priority if both occur in the same cycle.
REQ-017 In RESP, rsp_valid SHALL be 1 and rsp_c, rsp_id and rsp_err SHALL be stable; when rsp_ready=1 the block SHALL go to IDLE.
REQ-018 On leaving RUN, the operand registers SHALL be zeroized, so that core_p=0 and core_guard=0 in RESP and IDLE.
REQ-019 On leaving RESP, rsp_c SHALL be zeroized.
REQ-020 core_en SHALL be 0 in IDLE and RESP, so that core_en is low for at least one cycle between operations and the core restarts.
REQ-021 The block SHALL never combine shares: no XOR or other logic across share boundaries of p, c or guard; shares are only routed and registered.
REQ-022 reqN_ready SHALL be 0 in RUN and RESP. Requests arriving while the block is busy SHALL wait without being dropped.
REQ-023 Request-to-response latency SHALL be: 1 cycle (IDLE accept) + cycles until core_done + 1 cycle.

Reset
REQ-024 While rst=0, the block SHALL force the state to IDLE, the last-grant bit to 1 (requester 0 wins the first tie), and all registers and outputs to 0.
REQ-025 A reset asserted mid-RUN or mid-RESP SHALL discard the operation without emitting a response.

Structure
REQ-026 The state encoding and the TIMEOUT default SHALL live in the shared PRINCE package, next to the share-width constants (64-bit share, 4 shares, 12-bit guard).
REQ-027 The round-robin grant logic SHALL be the one natural sub-module, prince_rr_grant2, with inputs valid[1:0] and last and output grant[1:0].

Verification
REQ-028 The bench SHALL cover: req0 only, enc=1, p = shares of 0x0000000000000000 with a zero key, core model done after 12 cycles -> rsp_id=0, rsp_err=0, XOR of rsp_c shares = 0x818665aa0d02dfda.
REQ-029 The bench SHALL cover: req0 and req1 valid in the same cycle after reset -> grant to 0 first, then to 1; a second simultaneous pair -> grant to 0, then 1 (alternating).
REQ-030 The bench SHALL cover: core_done never asserted -> rsp_err=1 and rsp_c=0 exactly TIMEOUT+1 cycles after accept.
REQ-031 The bench SHALL cover: rsp_ready held low for 5 cycles -> rsp_valid and rsp_c stable, and req1_ready stays 0 throughout.
REQ-032 The bench SHALL cover: rst pulsed low mid-RUN -> busy=0, core_en=0 and rsp_valid=0 immediately, with no response afterwards.
REQ-033 The bench SHALL cover: after any completion -> core_p=0 and core_guard=0 in the cycle after leaving RUN.

Source files
------------

// File: rtl/prince_share_arbiter_pkg.sv
// Shared constants for the masked PRINCE datapath: share geometry, guard
// randomness width, arbiter FSM encoding and the default core timeout.
package prince_share_arbiter_pkg;

    localparam int SHARE_W         = 64;
    localparam int N_SHARES        = 4;
    localparam int DATA_W          = SHARE_W * N_SHARES;
    localparam int GUARD_W         = 12;
    localparam int TIMEOUT_DEFAULT = 15;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic               enc;
        logic [DATA_W-1:0]  p;
        logic [GUARD_W-1:0] guard;
    } operand_t;

endpackage

// File: rtl/prince_rr_grant2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
// `last` holds the index of the requester granted most recently.
module prince_rr_grant2
    import prince_share_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last)) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/prince_share_arbiter.sv
// Two-requester front end for a masked PRINCE core: arbitrates, feeds the core
// registered shares, and returns exactly one response per accepted request.
module prince_share_arbiter
    import prince_share_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_enc,
    input  logic [DATA_W-1:0]  req0_p,
    input  logic [GUARD_W-1:0] req0_guard,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_enc,
    input  logic [DATA_W-1:0]  req1_p,
    input  logic [GUARD_W-1:0] req1_guard,

    output logic               core_en,
    output logic               core_enc,
    output logic [DATA_W-1:0]  core_p,
    output logic [GUARD_W-1:0] core_guard,
    input  logic               core_done,
    input  logic [DATA_W-1:0]  core_c,

    output logic               rsp_valid,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  rsp_c,
    input  logic               rsp_ready,

    output logic               busy
);

    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               last_grant;
    logic [CNT_W-1:0]   run_cnt;
    operand_t           op;
    operand_t           req0_op;
    operand_t           req1_op;
    logic               rsp_id_q;
    logic               rsp_err_q;
    logic [DATA_W-1:0]  rsp_c_q;
    logic [1:0]         req_valid;
    logic [1:0]         grant;
    logic               in_idle;
    logic               in_run;
    logic               in_resp;
    logic               timed_out;
    logic               accept;
    logic               run_exit;
    logic               resp_exit;

    assign req_valid = {req1_valid, req0_valid};
    assign req0_op   = '{enc: req0_enc, p: req0_p, guard: req0_guard};
    assign req1_op   = '{enc: req1_enc, p: req1_p, guard: req1_guard};

    prince_rr_grant2 u_rr_grant (
        .valid (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign in_idle   = (state == ST_IDLE);
    assign in_run    = (state == ST_RUN);
    assign in_resp   = (state == ST_RESP);
    assign timed_out = (run_cnt == CNT_LAST);
    assign accept    = in_idle && (|grant);
    assign run_exit  = in_run && (core_done || timed_out);
    assign resp_exit = in_resp && rsp_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|grant)                    state_nxt = ST_RUN;
            ST_RUN:  if (core_done || timed_out)    state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready)                 state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
    end

    // Last-grant resets to 1 so requester 0 wins the very first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            rsp_id_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant[1];
                rsp_id_q   <= grant[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt <= '0;
        end else if (accept) begin
            run_cnt <= '0;
        end else if (in_run) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    // Operands exist only while the core runs; shares are never left behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op <= '0;
        end else if (accept) begin
            op <= grant[1] ? req1_op : req0_op;
        end else if (run_exit) begin
            op <= '0;
        end
    end

    // core_done outranks a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
        end else if (run_exit) begin
            rsp_c_q   <= core_done ? core_c : '0;
            rsp_err_q <= !core_done;
        end else if (resp_exit) begin
            rsp_c_q   <= '0;
            rsp_err_q <= 1'b0;
        end
    end

    // Ready is held off while reset is asserted even though the state reads IDLE.
    assign req0_ready = rst && in_idle && grant[0];
    assign req1_ready = rst && in_idle && grant[1];

    assign core_en    = in_run;
    assign core_enc   = op.enc;
    assign core_p     = op.p;
    assign core_guard = op.guard;

    assign rsp_valid  = in_resp;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_c      = rsp_c_q;

    assign busy       = !in_idle;

endmodule
